// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the block-scheduler FSM state encoding.
package aes_pkg;
   localparam int BLOCK_W        = 128;
   localparam int WORD_W         = 32;
   localparam int SBOX_LANES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/s_box.sv
// Single AES forward S-box cell: one byte in, one substituted byte out, purely combinational.
module s_box (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   // Entry for input byte b sits at bits [2047-8b -: 8] (entry 0 is the MSB).
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] idx;

   assign idx = 11'd2047 - {a_i, 3'b000};
   assign y_o = TBL[idx -: 8];
endmodule

// File: rtl/sbox_bank.sv
// Combinational bank of LANES parallel S-box cells; byte lane i maps bits [8i +: 8].
module sbox_bank #(
   parameter int LANES = 4
) (
   input  logic [8*LANES-1:0] din_i,
   output logic [8*LANES-1:0] dout_o
);
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      s_box u_sbox (
         .a_i (din_i[8*i +: 8]),
         .y_o (dout_o[8*i +: 8])
      );
   end
endmodule

// File: rtl/sbox_scheduler.sv
// Time-multiplexed SubBytes over a 128-bit block using SBOX_LANES shared S-box lanes.
// Optional macro SBOX_SHARE_KEY_EN shares the lane bank with a key-expansion SubWord requester.
module sbox_scheduler
   import aes_pkg::*;
#(
   parameter int SBOX_LANES = SBOX_LANES_DEF
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SBOX_SHARE_KEY_EN
   input  logic         kw_valid,
   output logic         kw_ready,
   input  logic [31:0]  kw_data,
   output logic         kw_out_valid,
   output logic [31:0]  kw_out,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   localparam int LANE_W = 8 * SBOX_LANES;
   localparam int NBEATS = 16 / SBOX_LANES;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
         SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("sbox_scheduler: SBOX_LANES must be 1, 2, 4, 8 or 16");
   end

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BLOCK_W-1:0]   blk_q;
   logic [BLOCK_W-1:0]   res_q, res_d;
   logic [LANE_W-1:0]    bank_in, bank_out;
   logic [BLOCK_W-1:0]   blk_shift, ins_w;
   logic [6:0]           shamt;
   logic                 beat_en;
   logic                 last_beat;

   assign shamt     = 7'(cnt_q) * 7'(LANE_W);
   assign blk_shift = blk_q << shamt;
   assign ins_w     = (BLOCK_W'(bank_out) << (BLOCK_W - LANE_W)) >> shamt;
   assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

`ifdef SBOX_SHARE_KEY_EN
   if (SBOX_LANES != 4) begin : g_bad_share
      $error("sbox_scheduler: SBOX_SHARE_KEY_EN requires SBOX_LANES == 4");
   end

   logic        last_kw_q;
   logic        kw_grant;
   logic        kw_out_valid_q;
   logic [31:0] kw_out_q;

   // Key word loses only when it won the previous contended RUN cycle.
   assign kw_ready     = kw_valid & ~((state_q == ST_RUN) & last_kw_q) & ~rst;
   assign kw_grant     = kw_valid & kw_ready;
   assign beat_en      = (state_q == ST_RUN) & ~kw_grant;
   assign bank_in      = kw_grant ? kw_data : blk_shift[BLOCK_W-1 -: LANE_W];
   assign kw_out_valid = kw_out_valid_q;
   assign kw_out       = kw_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_kw_q      <= 1'b0;
         kw_out_valid_q <= 1'b0;
         kw_out_q       <= '0;
      end else begin
         kw_out_valid_q <= kw_grant;
         if (kw_grant) begin
            kw_out_q  <= bank_out;
            last_kw_q <= 1'b1;
         end else if (beat_en) begin
            last_kw_q <= 1'b0;
         end
      end
   end
`else
   assign beat_en = (state_q == ST_RUN);
   assign bank_in = blk_shift[BLOCK_W-1 -: LANE_W];
`endif

   sbox_bank #(.LANES(SBOX_LANES)) u_bank (
      .din_i  (bank_in),
      .dout_o (bank_out)
   );

   assign in_ready  = (state_q == ST_IDLE) & ~rst;
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = res_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         ST_RUN: begin
            if (beat_en) begin
               res_d = res_q | ins_w;
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Block capture happens only on an IDLE handshake; RUN/DONE inputs are ignored.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ST_IDLE && in_valid) blk_q <= in_data;
   end
endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler with a SubBytes scoreboard built from a GF(2^8) reference.
module tb_sbox_scheduler;
   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] in_data;
   logic         rdy4, ov4;
   logic [127:0] od4;
   int           total = 0;
   int           bad = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   ref_sb[256];

   localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] SUB_A = 128'h638293c31bfc33f5c4eeacea4bc12816;

   always #5 clk = ~clk;

`ifdef SBOX_SHARE_KEY_EN
   logic        kw_valid, kw_ready, kw_out_valid;
   logic [31:0] kw_data, kw_out;

   sbox_scheduler #(.SBOX_LANES(4)) u4 (
      .clk(clk), .rst(rst),
      .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
      .kw_out_valid(kw_out_valid), .kw_out(kw_out),
      .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4));
`else
   logic         rdy1, ov1, rdy16, ov16;
   logic [127:0] od1, od16;

   sbox_scheduler #(.SBOX_LANES(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4));
   sbox_scheduler #(.SBOX_LANES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1));
   sbox_scheduler #(.SBOX_LANES(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
      .out_valid(ov16), .out_ready(out_ready), .out_data(od16));
`endif

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int c = 1; c < 256; c++)
         if (v != 8'h00 && gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sb[d[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, 1, 0);
      else chk(tag, od4, exp_q.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ov(input string tag, input int want);
      int n = 0;
      while (!ov4 && n < 30) begin
         step();
         #1;
         n++;
      end
      chk(tag, n, want);
   endtask

   initial begin
      int hs_c[$];
      int n;
      for (int i = 0; i < 256; i++) ref_sb[i] = sbox_ref(8'(i));

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef SBOX_SHARE_KEY_EN
      kw_valid = 1'b1; kw_data = 32'h01c2ff53;
`endif
      repeat (3) step();
      #1;
      chk("rst_out_valid", ov4, 0);
      chk("rst_out_data", od4, 0);
      chk("rst_in_ready", rdy4, 0);
`ifdef SBOX_SHARE_KEY_EN
      chk("rst_kw_ready", kw_ready, 0);
      chk("rst_kw_out_valid", kw_out_valid, 0);
      chk("rst_kw_out", kw_out, 0);
      kw_valid = 1'b0;
`endif
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", rdy4, 1);

      // Block A: latency per lane count, plus an ignored offer during RUN.
      in_data = BLK_A; in_valid = 1'b1; out_ready = 1'b1;
      exp_q.push_back(sub_bytes(BLK_A));
      step();
      for (int c = 1; c <= 17; c++) begin
         in_valid = (c == 2);
         in_data  = (c == 2) ? ~BLK_A : BLK_A;
         #1;
         chk("A_out_valid4", ov4, c == 5);
         if (c <= 8) chk("A_in_ready4", rdy4, c >= 6);
         if (ov4) begin
            pop_chk("A_data4");
            chk("A_literal4", od4, SUB_A);
         end
`ifndef SBOX_SHARE_KEY_EN
         chk("A_out_valid1", ov1, c == 17);
         chk("A_out_valid16", ov16, c == 2);
         if (ov1) chk("A_data1", od1, SUB_A);
         if (ov16) chk("A_data16", od16, SUB_A);
`endif
         step();
      end
      in_valid = 1'b0;

      // Block of zeros held in DONE by back-pressure.
      in_data = '0; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(sub_bytes('0));
      step();
      in_valid = 1'b0;
      #1;
      wait_ov("B_latency", 4);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = {4{32'hdeadbeef}};
         #1;
         chk("B_hold_valid", ov4, 1);
         chk("B_hold_data", od4, {16{8'h63}});
         chk("B_hold_ready", rdy4, 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      pop_chk("B_data");
      step();
      #1;
      chk("B_back_idle", rdy4, 1);

      // Reset during beat 2 discards the block.
      in_data = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("C_no_valid", ov4, 0);
         step();
      end
      in_data = 128'h3243f6a8885a308d313198a2e0370734; in_valid = 1'b1;
      exp_q.push_back(sub_bytes(in_data));
      step();
      in_valid = 1'b0;
      #1;
      wait_ov("C_latency", 4);
      pop_chk("C_data");
      step();

      // Continuous offers: one block every N+2 cycles.
      in_valid = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < 20; c++) begin
         #1;
         if (ov4) pop_chk("D_data");
         if (rdy4) begin
            exp_q.push_back(sub_bytes(in_data));
            hs_c.push_back(c);
         end
         step();
         if (hs_c.size() > 0 && hs_c[hs_c.size()-1] == c)
            in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      in_valid = 1'b0;
      chk("D_handshakes", hs_c.size(), 4);
      for (int i = 1; i < hs_c.size(); i++) chk("D_period", hs_c[i] - hs_c[i-1], 6);
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         #1;
         if (ov4) pop_chk("D_drain");
         step();
         n++;
      end

`ifdef SBOX_SHARE_KEY_EN
      // Shared bank: key word contends for every RUN cycle.
      begin
         int done_c = 99;
         int kw_n = 0;
         in_data = BLK_A; in_valid = 1'b1; kw_valid = 1'b1; kw_data = 32'h01c2ff53;
         exp_q.push_back(sub_bytes(BLK_A));
         step();
         in_valid = 1'b0;
         for (int c = 1; c <= 12; c++) begin
            #1;
            if (kw_out_valid) begin
               chk("K_kw_out", kw_out, 32'h7c2516ed);
               kw_n++;
            end
            if (ov4 && done_c == 99) begin
               done_c = c;
               pop_chk("K_data");
            end
            step();
         end
         kw_valid = 1'b0;
         chk("K_done_by_9", done_c <= 9, 1);
         chk("K_kw_grants", kw_n >= 4, 1);
      end
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
